backoff_retry_ctrl: RTL and testbench
=====================================

// Module: backoff_retry_ctrl
// PURPOSE
//  Retry sequencer for contended trials (atomics, lock acquires, arbitration attempts); sits directly upstream of exp_backoff.
//  Accepts one request, issues it downstream as a trial, and inspects the pass/fail result.
//  On failure it pulses the backoff set and waits for the backoff to expire before retrying.
//  On success or retry exhaustion it pulses the backoff clear and returns one response.
// PARAMETERS
//  DataWidth  32  width of request payload forwarded unchanged on every trial
//  MaxTrials  8   total trials per request incl. first (>=1); CntW = $clog2(MaxTrials+1)
// PORTS
//  clk_i              in   1          clock
//  rst_ni             in   1          async reset, active low
//  req_valid_i        in   1          request valid
//  req_ready_o        out  1          request ready (IDLE only)
//  req_data_i         in   DataWidth  request payload
//  trial_valid_o      out  1          trial issue valid
//  trial_ready_i      in   1          trial issue ready
//  trial_data_o       out  DataWidth  latched payload
//  result_valid_i     in   1          trial result strobe (1 cycle)
//  result_ok_i        in   1          1 = trial succeeded, qualified by result_valid_i
//  backoff_set_o      out  1          1-cycle pulse: trial failed, arm backoff (to exp_backoff set_i)
//  backoff_clr_o      out  1          1-cycle pulse: sequence done (to exp_backoff clr_i)
//  backoff_is_zero_i  in   1          backoff expired (from exp_backoff is_zero_o)
//  rsp_valid_o        out  1          response valid
//  rsp_ready_i        in   1          response ready
//  rsp_ok_o           out  1          final trial succeeded
//  rsp_exhausted_o    out  1          MaxTrials failures, gave up
//  rsp_tries_o        out  CntW       trials issued for this request (1..MaxTrials)
//  busy_o             out  1          state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, data_q=0, tries_q=0, ok_q=0, exh_q=0. All outputs 0 except req_ready_o=1.
//  FSM states: IDLE, ISSUE, WAIT_RES, BACKOFF, RESP. All outputs are functions of state/regs; trial_valid_o also uses backoff_is_zero_i.
//  IDLE: req_ready_o=1. On req fire: latch data_q, tries_q=0, ->ISSUE. Trial issue starts 1 cycle after request accept.
//  ISSUE: trial_valid_o = backoff_is_zero_i.
//   - Fire (valid&ready): tries_q++, ->WAIT_RES.
//   - trial_data_o=data_q is stable while trial_valid_o is held.
//  WAIT_RES: wait for result_valid_i.
//   - ok=1: backoff_clr_o=1 this cycle, ok_q=1, ->RESP.
//   - ok=0 and tries_q==MaxTrials: backoff_clr_o=1, exh_q=1, ok_q=0, ->RESP.
//   - ok=0 otherwise: backoff_set_o=1 this cycle, ->BACKOFF.
//  BACKOFF: backoff_is_zero_i is sampled starting the cycle after the set pulse, because the counter updates on that edge.
//   - is_zero=1: ->ISSUE. Minimum 1 cycle in BACKOFF.
//  RESP: rsp_valid_o=1. rsp_ok_o/rsp_exhausted_o/rsp_tries_o are held stable until rsp_ready_i; then clear ok_q/exh_q, ->IDLE.
//  Pulse rules:
//   - backoff_set_o and backoff_clr_o are never high together.
//   - Each is high at most 1 cycle per result.
//   - Exactly one clr per request.
//  result_valid_i outside WAIT_RES is ignored; no state change, no pulses.
//  Results that arrive in the same cycle as the trial fire are not accepted. Downstream latency is >=1 cycle.
//  rsp_ok_o and rsp_exhausted_o are mutually exclusive. MaxTrials=1: first failure gives exhausted, with no set pulse.
//  tries_q saturates at MaxTrials; no wrap.
//  Async reset mid-operation (any state): immediate return to reset values. In-flight request/result are dropped; no pulses emitted.
//  Assertions: MaxTrials>=1; set&clr never both 1; rsp fields stable while rsp_valid_o&!rsp_ready_i.
// TESTING
//  1. Req data=0xA5, result ok on first trial -> trial_data=0xA5 once, 1 clr pulse, 0 set, rsp ok=1 exh=0 tries=1.
//  2. Fail, fail, ok with is_zero low 5 cycles after each set -> trial_valid low those 5 cycles, 2 set pulses, 1 clr, rsp ok=1 tries=3.
//  3. MaxTrials=8, all results fail -> 7 set pulses, 1 clr, rsp ok=0 exh=1 tries=8.
//  4. rsp_ready_i low 10 cycles -> rsp_valid/fields held stable, req_ready_o=0, next req accepted cycle after rsp fire.
//  5. trial_ready_i low 4 cycles -> trial_valid/data held; result_valid pulsed in IDLE -> ignored, no pulses.
//  6. rst_ni asserted during BACKOFF -> all outputs reset values, req_ready_o=1 after release, no set/clr emitted.

Source files
------------

// File: rtl/backoff_retry_ctrl_if.sv
// rtl/backoff_retry_ctrl_if.sv - request, trial, backoff and response signals of the retry sequencer
interface backoff_retry_ctrl_if #(
   parameter int DataWidth = 32,
   parameter int CntW      = 4
);
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic [DataWidth-1:0] req_data_i;
   logic                 trial_valid_o;
   logic                 trial_ready_i;
   logic [DataWidth-1:0] trial_data_o;
   logic                 result_valid_i;
   logic                 result_ok_i;
   logic                 backoff_set_o;
   logic                 backoff_clr_o;
   logic                 backoff_is_zero_i;
   logic                 rsp_valid_o;
   logic                 rsp_ready_i;
   logic                 rsp_ok_o;
   logic                 rsp_exhausted_o;
   logic [CntW-1:0]      rsp_tries_o;
   logic                 busy_o;

   // master is the sequencer itself; slave is the surrounding requester/downstream/backoff logic
   modport master (
      input  req_valid_i, req_data_i, trial_ready_i, result_valid_i, result_ok_i,
             backoff_is_zero_i, rsp_ready_i,
      output req_ready_o, trial_valid_o, trial_data_o, backoff_set_o, backoff_clr_o,
             rsp_valid_o, rsp_ok_o, rsp_exhausted_o, rsp_tries_o, busy_o
   );

   modport slave (
      output req_valid_i, req_data_i, trial_ready_i, result_valid_i, result_ok_i,
             backoff_is_zero_i, rsp_ready_i,
      input  req_ready_o, trial_valid_o, trial_data_o, backoff_set_o, backoff_clr_o,
             rsp_valid_o, rsp_ok_o, rsp_exhausted_o, rsp_tries_o, busy_o
   );
endinterface

// File: rtl/backoff_retry_ctrl.sv
// rtl/backoff_retry_ctrl.sv - retry sequencer that reissues a failed trial after an exp_backoff delay
module backoff_retry_ctrl #(
   parameter int DataWidth = 32,
   parameter int MaxTrials = 8
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   backoff_retry_ctrl_if.master bus
);
   localparam int CntW = $clog2(MaxTrials + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTrials);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, BACKOFF, RESP} state_e;

   state_e               state_q, state_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic [CntW-1:0]      tries_q, tries_d;
   logic                 ok_q, ok_d;
   logic                 exh_q, exh_d;

   logic req_ready, trial_valid, set_pulse, clr_pulse, rsp_valid;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         data_q  <= '0;
         tries_q <= '0;
         ok_q    <= 1'b0;
         exh_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         tries_q <= tries_d;
         ok_q    <= ok_d;
         exh_q   <= exh_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      tries_d     = tries_q;
      ok_d        = ok_q;
      exh_d       = exh_q;
      req_ready   = 1'b0;
      trial_valid = 1'b0;
      set_pulse   = 1'b0;
      clr_pulse   = 1'b0;
      rsp_valid   = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid_i) begin
               data_d  = bus.req_data_i;
               tries_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // never offer a trial while the backoff counter is still running
            trial_valid = bus.backoff_is_zero_i;
            if (bus.backoff_is_zero_i && bus.trial_ready_i) begin
               if (tries_q != MaxCnt) tries_d = tries_q + 1'b1;
               state_d = WAIT_RES;
            end
         end
         WAIT_RES: begin
            if (bus.result_valid_i) begin
               if (bus.result_ok_i) begin
                  clr_pulse = 1'b1;
                  ok_d      = 1'b1;
                  state_d   = RESP;
               end else if (tries_q == MaxCnt) begin
                  clr_pulse = 1'b1;
                  exh_d     = 1'b1;
                  ok_d      = 1'b0;
                  state_d   = RESP;
               end else begin
                  set_pulse = 1'b1;
                  state_d   = BACKOFF;
               end
            end
         end
         BACKOFF: begin
            // the counter was armed on the edge that entered this state, so is_zero is fresh here
            if (bus.backoff_is_zero_i) state_d = ISSUE;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready_i) begin
               ok_d    = 1'b0;
               exh_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready_o     = req_ready;
   assign bus.trial_valid_o   = trial_valid;
   assign bus.trial_data_o    = data_q;
   assign bus.backoff_set_o   = set_pulse;
   assign bus.backoff_clr_o   = clr_pulse;
   assign bus.rsp_valid_o     = rsp_valid;
   assign bus.rsp_ok_o        = ok_q;
   assign bus.rsp_exhausted_o = exh_q;
   assign bus.rsp_tries_o     = tries_q;
   assign bus.busy_o          = (state_q != IDLE);

   a_max_trials: assert property (@(posedge clk_i) MaxTrials >= 1);
   a_set_clr_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(set_pulse && clr_pulse));
   a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (rsp_valid && !bus.rsp_ready_i) |=> (rsp_valid && $stable({ok_q, exh_q, tries_q})));
endmodule

// File: tb/tb_backoff_retry_ctrl.sv
// tb/tb_backoff_retry_ctrl.sv - table-driven scoreboard bench for backoff_retry_ctrl
`timescale 1ns/1ps
module tb_backoff_retry_ctrl;
   localparam int DataWidth = 32;
   localparam int MaxTrials = 8;
   localparam int CntW      = $clog2(MaxTrials + 1);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   backoff_retry_ctrl_if #(.DataWidth(DataWidth), .CntW(CntW)) bus ();
   backoff_retry_ctrl #(.DataWidth(DataWidth), .MaxTrials(MaxTrials)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [DataWidth-1:0] data;
      int   nfail;
      int   bo_len;
      int   trial_stall;
      int   rsp_stall;
      logic exp_ok;
      logic exp_exh;
      int   exp_tries;
      int   exp_sets;
   } vec_t;

   typedef struct {
      logic ok;
      logic exh;
      int   tries;
      int   sets;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   vec_t vecs[6];

   int assert_cnt = 0;
   int fail_cnt   = 0;
   int cyc = 0;
   int set_cnt = 0, clr_cnt = 0, trial_cnt = 0, last_set_cyc = 0, cur_bo_len = 0, bo_cnt = 0;
   bit pend = 0, trial_hold = 0, rsp_hold = 0;
   logic [DataWidth-1:0] exp_data = '0, hold_data;
   logic [CntW+1:0] hold_rsp;
   logic s_set, s_clr;

   function automatic void check(input string name, input longint act, input longint req);
      assert_cnt++;
      if (act != req) begin
         fail_cnt++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   function automatic void check_reset(input string tag);
      check({tag, "_req_ready"}, bus.req_ready_o, 1);
      check({tag, "_trial_valid"}, bus.trial_valid_o, 0);
      check({tag, "_trial_data"}, bus.trial_data_o, 0);
      check({tag, "_set"}, bus.backoff_set_o, 0);
      check({tag, "_clr"}, bus.backoff_clr_o, 0);
      check({tag, "_rsp_valid"}, bus.rsp_valid_o, 0);
      check({tag, "_rsp_fields"}, {bus.rsp_ok_o, bus.rsp_exhausted_o, bus.rsp_tries_o}, 0);
      check({tag, "_busy"}, bus.busy_o, 0);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // behavioural exp_backoff: loads cur_bo_len on set, counts down once per cycle
   always begin
      @(negedge clk);
      s_set = bus.backoff_set_o;
      s_clr = bus.backoff_clr_o;
      @(posedge clk);
      #1;
      if (!rst_n) bo_cnt = 0;
      else if (s_set) bo_cnt = cur_bo_len;
      else if (s_clr) bo_cnt = 0;
      else if (bo_cnt > 0) bo_cnt--;
      bus.backoff_is_zero_i = (bo_cnt == 0);
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         trial_hold = 0;
         rsp_hold   = 0;
      end else begin
         if (bus.req_valid_i && bus.req_ready_o) begin
            set_cnt = 0; clr_cnt = 0; trial_cnt = 0; pend = 0;
         end
         if (bus.backoff_set_o || bus.backoff_clr_o)
            check("set_clr_excl", bus.backoff_set_o && bus.backoff_clr_o, 0);
         if (bus.backoff_set_o) begin
            set_cnt++; last_set_cyc = cyc; pend = 1;
         end
         if (bus.backoff_clr_o) clr_cnt++;
         if (trial_hold) begin
            check("trial_hold_valid", bus.trial_valid_o, 1);
            check("trial_hold_data", bus.trial_data_o, hold_data);
         end
         trial_hold = bus.trial_valid_o && !bus.trial_ready_i;
         hold_data  = bus.trial_data_o;
         if (bus.trial_valid_o && bus.trial_ready_i) begin
            check("trial_data", bus.trial_data_o, exp_data);
            trial_cnt++;
            if (pend) begin
               check("backoff_latency", cyc - last_set_cyc, cur_bo_len + 2);
               pend = 0;
            end
         end
         if (rsp_hold) begin
            check("rsp_hold_valid", bus.rsp_valid_o, 1);
            check("rsp_hold_fields", {bus.rsp_ok_o, bus.rsp_exhausted_o, bus.rsp_tries_o}, hold_rsp);
         end
         rsp_hold = bus.rsp_valid_o && !bus.rsp_ready_i;
         hold_rsp = {bus.rsp_ok_o, bus.rsp_exhausted_o, bus.rsp_tries_o};
         if (bus.rsp_valid_o) check("req_ready_in_resp", bus.req_ready_o, 0);
         if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (sb_q.size() == 0) check("sb_unexpected_rsp", 1, 0);
            else begin
               e = sb_q.pop_front();
               check("rsp_ok", bus.rsp_ok_o, e.ok);
               check("rsp_exhausted", bus.rsp_exhausted_o, e.exh);
               check("rsp_tries", bus.rsp_tries_o, e.tries);
               check("trial_count", trial_cnt, e.tries);
               check("set_pulses", set_cnt, e.sets);
               check("clr_pulses", clr_cnt, 1);
            end
         end
      end
   end

   task automatic wait_for(input int kind, input string name);
      int  n = 0;
      bit  hit = 0;
      do begin
         @(negedge clk);
         case (kind)
            0:       hit = bus.req_ready_o;
            1:       hit = bus.trial_valid_o && bus.trial_ready_i;
            2:       hit = bus.rsp_valid_o && bus.rsp_ready_i;
            default: hit = bus.backoff_set_o;
         endcase
         n++;
      end while (!hit && n < 200);
      if (!hit) check({"timeout_", name}, 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input vec_t v);
      sb_q.push_back('{v.exp_ok, v.exp_exh, v.exp_tries, v.exp_sets});
      exp_data   = v.data;
      cur_bo_len = v.bo_len;
      bus.req_data_i  = v.data;
      bus.req_valid_i = 1'b1;
      wait_for(0, "req");
      bus.req_valid_i = 1'b0;
      bus.req_data_i  = ~v.data;
      for (int i = 0; i < v.exp_tries; i++) begin
         bus.trial_ready_i = !(i == 0 && v.trial_stall > 0);
         if (i == 0 && v.trial_stall > 0) begin
            repeat (v.trial_stall) @(posedge clk);
            #1;
            bus.trial_ready_i = 1'b1;
         end
         wait_for(1, "trial");
         bus.trial_ready_i = 1'b0;
         @(posedge clk);
         #1;
         bus.result_valid_i = 1'b1;
         bus.result_ok_i    = (i >= v.nfail);
         @(posedge clk);
         #1;
         bus.result_valid_i = 1'b0;
         bus.result_ok_i    = 1'b0;
      end
      bus.rsp_ready_i = (v.rsp_stall == 0);
      if (v.rsp_stall > 0) begin
         repeat (v.rsp_stall) @(posedge clk);
         #1;
         bus.rsp_ready_i = 1'b1;
      end
      wait_for(2, "rsp");
      bus.rsp_ready_i = 1'b0;
      check("req_ready_after_rsp", bus.req_ready_o, 1);
      check("busy_after_rsp", bus.busy_o, 0);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid_i    = 1'b0;
      bus.req_data_i     = '0;
      bus.trial_ready_i  = 1'b0;
      bus.result_valid_i = 1'b0;
      bus.result_ok_i    = 1'b0;
      bus.rsp_ready_i    = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      //          data           nfail bo ts rs  ok    exh   tries sets
      vecs[0] = '{32'h0000_00A5, 0,    0, 0, 0,  1'b1, 1'b0, 1,    0};
      vecs[1] = '{32'h0000_003C, 2,    5, 0, 0,  1'b1, 1'b0, 3,    2};
      vecs[2] = '{32'hDEAD_BEEF, 8,    1, 0, 0,  1'b0, 1'b1, 8,    7};
      vecs[3] = '{32'h1234_5678, 0,    0, 0, 10, 1'b1, 1'b0, 1,    0};
      vecs[4] = '{32'h0000_0000, 1,    0, 4, 0,  1'b1, 1'b0, 2,    1};
      vecs[5] = '{32'hFFFF_FFFF, 7,    2, 0, 3,  1'b1, 1'b0, 8,    7};
      for (int k = 0; k < 6; k++) run_req(vecs[k]);

      // stray result while idle must be ignored
      bus.result_valid_i = 1'b1;
      bus.result_ok_i    = 1'b0;
      @(negedge clk);
      check("idle_result_set", bus.backoff_set_o, 0);
      check("idle_result_clr", bus.backoff_clr_o, 0);
      @(posedge clk);
      #1;
      bus.result_valid_i = 1'b0;
      check("idle_result_busy", bus.busy_o, 0);
      check("idle_result_req_ready", bus.req_ready_o, 1);
      check("idle_result_rsp_valid", bus.rsp_valid_o, 0);

      // asynchronous reset while waiting out a long backoff
      exp_data   = 32'h0000_0077;
      cur_bo_len = 20;
      bus.req_data_i  = 32'h0000_0077;
      bus.req_valid_i = 1'b1;
      wait_for(0, "rst_req");
      bus.req_valid_i   = 1'b0;
      bus.trial_ready_i = 1'b1;
      wait_for(1, "rst_trial");
      bus.trial_ready_i = 1'b0;
      @(posedge clk);
      #1;
      bus.result_valid_i = 1'b1;
      bus.result_ok_i    = 1'b0;
      @(posedge clk);
      #1;
      bus.result_valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check("rst_busy_before", bus.busy_o, 1);
      rst_n = 1'b0;
      #1;
      check_reset("rst_mid");
      check("rst_set_pulses", set_cnt, 1);
      check("rst_clr_pulses", clr_cnt, 0);
      @(posedge clk);
      #1;
      check_reset("rst_hold");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release_req_ready", bus.req_ready_o, 1);
      run_req(vecs[1]);
      check("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end
endmodule
